serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Parametrised bit-serial adder/subtractor, LSB first, one bit per clock.
//   Generalises the fixed 4-bit serial adder: WIDTH operand width,
//   start/busy/done handshake, add or two's-complement subtract mode,
//   and carry/signed-overflow flags.
//   Sits between register-file operands and a result consumer where area
//   matters more than latency.
// PARAMETERS
//   WIDTH  4  operand width in bits (>=2); result is WIDTH+1 bits
// PORTS
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-high reset
//   start     in   1        request; operands and mode sampled when accepted
//   sub       in   1        0 = a+b, 1 = a-b (sampled with start)
//   a         in   WIDTH    operand A (unsigned or two's complement)
//   b         in   WIDTH    operand B
//   busy      out  1        high while bits are being processed
//   done      out  1        high when sum/flags valid; held until next accept
//   sum       out  WIDTH+1  {carry_out, result[WIDTH-1:0]}
//   overflow  out  1        signed overflow of result[WIDTH-1:0]
// BEHAVIOUR
//   Reset (async, active-high)
//   - state=IDLE; busy=0, done=0, sum=0, overflow=0.
//   - Bit counter, shift registers and carry are all cleared.
//   - Takes effect immediately, including mid-operation; partial result is discarded.
//   FSM states: IDLE, SHIFT, DONE
//   - IDLE/DONE, start=1 at edge E: accept.
//       - Latch a into shift reg A, and b^{WIDTH{sub}} into shift reg B.
//       - carry<=sub, cnt<=0, done<=0, busy<=1, state<=SHIFT.
//   - SHIFT, each edge:
//       - s = A[0]^B[0]^carry; carry <= majority(A[0],B[0],carry).
//       - R <= {s,R[WIDTH-1:1]}; A, B shift right; cnt++.
//   - SHIFT, edge when cnt==WIDTH-1 (edge E+WIDTH): last bit processed.
//       - sum <= {carry_next, result}.
//       - overflow <= carry into MSB XOR carry out of MSB.
//       - busy<=0, done<=1, state<=DONE.
//   - DONE, start=0: hold sum, overflow, done indefinitely.
//   - start while busy (SHIFT): ignored; operands not resampled.
//   Latency and throughput
//   - Accept edge E -> done high after edge E+WIDTH.
//   - start held high in DONE restarts at the next edge; done drops at that edge.
//     Back-to-back throughput is therefore one result per WIDTH+1 cycles.
//   Arithmetic
//   - Add: sum = a+b, exact unsigned (WIDTH+1 bits).
//   - Sub: sum[WIDTH-1:0] = (a-b) mod 2^WIDTH; sum[WIDTH]=1 means no borrow
//     (a>=b unsigned).
//   - overflow is meaningful for signed interpretation in both modes.
//   - sum/overflow change only at the completing edge or reset, never mid-shift.
// TESTING
//   1 W=4 add 1011+0110, reset released, start 1 cycle
//     -> busy 4 cycles, done after 4 edges, sum=10001, overflow=0.
//   2 W=4 sub 0110-1011 -> sum=01011 (borrow), overflow=1 (6-(-5)=11).
//   3 W=4 add 0111+0001 -> sum=01000, overflow=1.
//     W=4 sub 0101-0101 -> sum=10000, overflow=0.
//   4 start re-pulsed mid-SHIFT with new a/b -> ignored; first result unchanged.
//     Assert start in DONE -> done drops next edge, new result WIDTH edges later.
//   5 assert reset at cnt=2 -> busy/done/sum/overflow=0 immediately (async).
//     Fresh start after release completes correctly.
//   6 W=8: 0xFF+0x01 -> sum=0x100, overflow=0.
//     0x80-0x01 -> sum=0x17F, overflow=1.
//     Random 1000 ops vs reference model.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, one operand bit per clock.
// Produces {carry_out, result} plus a signed-overflow flag after WIDTH shift cycles.
module serial_addsub #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic             overflow
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic            carry;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            last;
    logic            bit_s;
    logic            carry_next;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is ignored while shifting
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) state_next = DONE;
            DONE:    if (start) state_next = SHIFT;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes and full-adder slice
    always_comb begin
        accept     = 1'b0;
        last       = 1'b0;
        bit_s      = 1'b0;
        carry_next = 1'b0;
        accept     = start && (state != SHIFT);
        last       = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
        bit_s      = sh_a[0] ^ sh_b[0] ^ carry;
        carry_next = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    end

    // Datapath: operand shifters, carry, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: invert B and seed the carry with sub
            sh_a  <= a;
            sh_b  <= b ^ {WIDTH{sub}};
            res   <= '0;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (state == SHIFT) begin
            sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
            sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
            res   <= {bit_s, res[WIDTH-1:1]};
            carry <= carry_next;
            cnt   <= cnt + CW'(1);
            if (last) begin
                // carry still holds the carry into the MSB at this edge
                sum      <= {carry_next, bit_s, res[WIDTH-1:1]};
                overflow <= carry ^ carry_next;
                busy     <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub at WIDTH=4 and WIDTH=8,
// including restart, ignored-start and async-reset sequences.
module tb_serial_addsub;

    logic       clk;
    logic       reset;
    logic       sub;
    logic       start4;
    logic       start8;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy4;
    logic       done4;
    logic [4:0] sum4;
    logic       ovf4;
    logic       busy8;
    logic       done8;
    logic [8:0] sum8;
    logic       ovf8;

    int applied;
    int miscompares;

    typedef struct {
        logic       sub;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] sum;
        logic       ovf;
    } vec4_t;

    vec4_t vt[8];

    serial_addsub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .overflow(ovf4)
    );

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .overflow(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signed/unsigned reference for WIDTH=8, returns {overflow, sum[8:0]}
    function automatic logic [9:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] r;
        logic       v;
        if (s) begin
            r = 9'(x) + 9'(8'hFF - y) + 9'd1;
            v = (x[7] != y[7]) && (r[7] != x[7]);
        end else begin
            r = 9'(x) + 9'(y);
            v = (x[7] == y[7]) && (r[7] != x[7]);
        end
        return {v, r};
    endfunction

    task automatic run4(input string tag, input logic s, input logic [3:0] x, input logic [3:0] y,
                        input logic [4:0] es, input logic eo);
        @(negedge clk);
        sub = s; a4 = x; b4 = y; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check($sformatf("%s.busy", tag), 32'(busy4), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("%s.not_done", tag), 32'(done4), 32'd0);
        @(posedge clk); #1;
        check($sformatf("%s.done", tag), 32'(done4), 32'd1);
        check($sformatf("%s.idle", tag), 32'(busy4), 32'd0);
        check($sformatf("%s.sum", tag), 32'(sum4), 32'(es));
        check($sformatf("%s.ovf", tag), 32'(ovf4), 32'(eo));
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y);
        logic [9:0] e;
        e = ref8(s, x, y);
        @(negedge clk);
        sub = s; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check($sformatf("%s.not_done", tag), 32'(done8), 32'd0);
        @(posedge clk); #1;
        check($sformatf("%s.done", tag), 32'(done8), 32'd1);
        check($sformatf("%s.sum", tag), 32'(sum8), 32'(e[8:0]));
        check($sformatf("%s.ovf", tag), 32'(ovf8), 32'(e[9]));
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        vt[0] = '{1'b0, 4'b1011, 4'b0110, 5'b10001, 1'b0};
        vt[1] = '{1'b1, 4'b0110, 4'b1011, 5'b01011, 1'b1};
        vt[2] = '{1'b0, 4'b0111, 4'b0001, 5'b01000, 1'b1};
        vt[3] = '{1'b1, 4'b0101, 4'b0101, 5'b10000, 1'b0};
        vt[4] = '{1'b0, 4'b1000, 4'b1000, 5'b10000, 1'b1};
        vt[5] = '{1'b1, 4'b0000, 4'b0001, 5'b01111, 1'b0};
        vt[6] = '{1'b1, 4'b1000, 4'b0001, 5'b10111, 1'b1};
        vt[7] = '{1'b0, 4'b1111, 4'b1111, 5'b11110, 1'b0};

        reset = 1'b1; start4 = 1'b0; start8 = 1'b0; sub = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy4), 32'd0);
        check("rst.done", 32'(done4), 32'd0);
        check("rst.sum", 32'(sum4), 32'd0);
        check("rst.ovf", 32'(ovf4), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run4($sformatf("v%0d", i), vt[i].sub, vt[i].a, vt[i].b, vt[i].sum, vt[i].ovf);
        end

        // start re-pulsed mid-shift with new operands must be ignored
        @(negedge clk);
        sub = 1'b0; a4 = 4'b0011; b4 = 4'b0001; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        sub = 1'b1; a4 = 4'b1111; b4 = 4'b0111; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("ign.busy", 32'(busy4), 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        check("ign.done", 32'(done4), 32'd1);
        check("ign.sum", 32'(sum4), 32'b00100);
        check("ign.ovf", 32'(ovf4), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold.done", 32'(done4), 32'd1);
        check("hold.sum", 32'(sum4), 32'b00100);

        // restart from DONE: done drops at the accept edge, sum held until completion
        @(negedge clk);
        sub = 1'b0; a4 = 4'b0010; b4 = 4'b0011; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("rs.done_drop", 32'(done4), 32'd0);
        check("rs.busy", 32'(busy4), 32'd1);
        check("rs.sum_held", 32'(sum4), 32'b00100);
        repeat (3) @(posedge clk);
        #1;
        check("rs.mid_sum", 32'(sum4), 32'b00100);
        @(posedge clk); #1;
        check("rs.done", 32'(done4), 32'd1);
        check("rs.sum", 32'(sum4), 32'b00101);

        // async reset at cnt=2 clears everything before the next edge
        @(negedge clk);
        sub = 1'b0; a4 = 4'b0111; b4 = 4'b0111; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("arst.busy", 32'(busy4), 32'd0);
        check("arst.done", 32'(done4), 32'd0);
        check("arst.sum", 32'(sum4), 32'd0);
        check("arst.ovf", 32'(ovf4), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run4("post_rst", 1'b0, 4'b0111, 4'b0111, 5'b01110, 1'b1);

        run8("w8_ff_p_01", 1'b0, 8'hFF, 8'h01);
        check("w8_ff_p_01.lit_sum", 32'(sum8), 32'h100);
        check("w8_ff_p_01.lit_ovf", 32'(ovf8), 32'd0);
        run8("w8_80_m_01", 1'b1, 8'h80, 8'h01);
        check("w8_80_m_01.lit_sum", 32'(sum8), 32'h17F);
        check("w8_80_m_01.lit_ovf", 32'(ovf8), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            run8($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
